vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port coin  input  2  coin strobe per cycle: 00 none, 01 = 5 units, 10 = 10 units, 11 = invalid.
REQ-004 SHALL have port select  input  2  button per cycle: 00 none, 01 product A (price 10), 10 product B (price 15), 11 cancel.
REQ-005 SHALL have port hopper_ready  input  1  change hopper accepts current change coin.
REQ-006 SHALL have port dispense_A  output  1  one-cycle pulse, vend product A.
REQ-007 SHALL have port dispense_B  output  1  one-cycle pulse, vend product B.
REQ-008 SHALL have port change_valid  output  1  change coin request to hopper.
REQ-009 SHALL have port change_coin  output  2  coin requested: 01 = 5 units, 10 = 10 units, 00 when change_valid low.
REQ-010 SHALL have port coin_reject  output  1  one-cycle pulse, offered coin not credited.
REQ-011 SHALL have port credit  output  6  current credit in units, registered.
REQ-012 SHALL have port busy  output  1  high in VEND or PAYOUT.

Function
REQ-013 SHALL implement FSM states IDLE (credit 0), COLLECT (credit > 0), VEND, PAYOUT.
REQ-014 SHALL, in IDLE/COLLECT, add a valid coin to credit at the sampling edge, credit visible next cycle; IDLE->COLLECT on first credited coin.
REQ-015 SHALL reject (coin_reject pulse next cycle, credit unchanged) any coin 11, any coin arriving in VEND/PAYOUT, and any coin making credit exceed 30.
REQ-016 SHALL, in COLLECT, on select A/B with credit >= price, go to VEND; select with insufficient credit SHALL be ignored, state and credit unchanged.
REQ-017 SHALL, when coin and select arrive in the same cycle, evaluate select against pre-coin credit and reject the coin.
REQ-018 SHALL assert dispense_A or dispense_B for exactly the one VEND cycle, set credit = credit - price, then go to PAYOUT if remainder > 0 else IDLE.
REQ-019 SHALL treat select 11 (cancel) in COLLECT as a refund: go directly to PAYOUT with full credit; cancel in IDLE is ignored.
REQ-020 SHALL, in PAYOUT, pay 10-unit coins while credit >= 10, then 5-unit coins, holding change_valid and change_coin stable until hopper_ready is sampled high.
REQ-021 SHALL, on each change_valid & hopper_ready edge, decrement credit by the coin value; at credit 0 go to IDLE with change_valid low the next cycle.
REQ-022 SHALL ignore select entirely while busy.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, credit 0, and all outputs 0, including mid-VEND or mid-PAYOUT (pending change discarded).
REQ-024 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Configuration
REQ-025 SHALL support macro VEND_TIMEOUT_EN: when defined, an 8-bit idle counter in COLLECT, cleared by any credited coin or select, SHALL force PAYOUT of full credit when it reaches 255 cycles.
REQ-026 SHALL, without VEND_TIMEOUT_EN, hold COLLECT credit indefinitely with no counter logic present.

Verification
REQ-027 SHALL cover: coin 10, select A -> dispense_A one pulse, credit 0, no change_valid, back to IDLE.
REQ-028 SHALL cover: coins 10,10, select B, hopper_ready held low 3 cycles then high -> dispense_B, change_valid with change_coin 01 held 3 cycles, one 5-unit coin, credit 0.
REQ-029 SHALL cover: coins 10,10,10 then coin 5 -> 5 rejected (coin_reject), credit 30; cancel -> three 10-unit change coins, hopper_ready always high.
REQ-030 SHALL cover: coin 5, select A -> ignored, credit 5; coin 10 same cycle as select B -> B not vended, coin rejected, credit 5.
REQ-031 SHALL cover: coins 10,10, select A, reset_n low during PAYOUT -> all outputs 0, credit 0, IDLE.
REQ-032 SHALL cover, with VEND_TIMEOUT_EN: coin 5 then 255 idle cycles -> one 5-unit change coin paid, IDLE.

Source files
------------

// File: rtl/vend_controller.sv
// Vending machine controller: coin collection, product vend, change payout.
// States: IDLE (no credit), COLLECT (credit held), VEND (one-cycle dispense),
// PAYOUT (change coins handed to hopper with a valid/ready handshake).
// Optional build macro VEND_TIMEOUT_EN: an abandoned COLLECT session is
// refunded automatically after 255 quiet cycles.
module vend_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] coin,
    input  logic [1:0] select,
    input  logic       hopper_ready,
    output logic       dispense_A,
    output logic       dispense_B,
    output logic       change_valid,
    output logic [1:0] change_coin,
    output logic       coin_reject,
    output logic [5:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_PAYOUT  = 2'd3
    } state_t;

    localparam logic [5:0] PRICE_A   = 6'd10;
    localparam logic [5:0] PRICE_B   = 6'd15;
    localparam logic [5:0] MAX_CRED  = 6'd30;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_credit;
    logic       r_prod_b;       // product latched at purchase: 0 = A, 1 = B
    logic       r_coin_reject;

    logic [5:0] w_coin_val;
    logic [5:0] w_coin_sum;
    logic       w_accepting;
    logic       w_sel_active;
    logic       w_coin_credit;
    logic       w_coin_rej;
    logic [5:0] w_sel_price;
    logic       w_buy;
    logic       w_cancel;
    logic [5:0] w_vend_price;
    logic [5:0] w_vend_remain;
    logic [5:0] w_change_val;
    logic       w_pay_fire;
    logic       w_timeout;

    assign w_coin_val    = (coin == 2'b01) ? 6'd5 : (coin == 2'b10) ? 6'd10 : 6'd0;
    assign w_coin_sum    = r_credit + w_coin_val;
    assign w_accepting   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_sel_active  = (select != 2'b00);
    // A coin that arrives together with any button press is turned away so the
    // button is always judged against the credit already held.
    assign w_coin_credit = w_accepting && (w_coin_val != 6'd0) && !w_sel_active &&
                           (w_coin_sum <= MAX_CRED);
    assign w_coin_rej    = (coin != 2'b00) && !w_coin_credit;
    assign w_sel_price   = (select == 2'b10) ? PRICE_B : PRICE_A;
    assign w_buy         = (r_state == S_COLLECT) &&
                           ((select == 2'b01) || (select == 2'b10)) &&
                           (r_credit >= w_sel_price);
    assign w_cancel      = (r_state == S_COLLECT) && (select == 2'b11);
    assign w_vend_price  = r_prod_b ? PRICE_B : PRICE_A;
    assign w_vend_remain = r_credit - w_vend_price;
    assign w_change_val  = (r_credit >= 6'd10) ? 6'd10 : 6'd5;
    assign w_pay_fire    = (r_state == S_PAYOUT) && hopper_ready;

`ifdef VEND_TIMEOUT_EN
    logic [7:0] r_idle_cnt;

    // Quiet-cycle counter for an abandoned COLLECT session
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= 8'd0;
        end else if ((r_state != S_COLLECT) || w_coin_credit || w_sel_active) begin
            r_idle_cnt <= 8'd0;
        end else if (r_idle_cnt != 8'hFF) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == S_COLLECT) && (r_idle_cnt == 8'hFF) && !w_sel_active;
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_coin_credit) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_buy)                      w_state_nxt = S_VEND;
                else if (w_cancel || w_timeout) w_state_nxt = S_PAYOUT;
            end
            S_VEND: begin
                w_state_nxt = (w_vend_remain != 6'd0) ? S_PAYOUT : S_IDLE;
            end
            S_PAYOUT: begin
                if (w_pay_fire && (r_credit == w_change_val)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Credit, latched product and coin-reject pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credit      <= 6'd0;
            r_prod_b      <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= w_coin_rej;
            if (w_buy) begin
                r_prod_b <= (select == 2'b10);
            end
            if (w_coin_credit) begin
                r_credit <= w_coin_sum;
            end else if (r_state == S_VEND) begin
                r_credit <= w_vend_remain;
            end else if (w_pay_fire) begin
                r_credit <= r_credit - w_change_val;
            end
        end
    end

    // Output decode from state
    always_comb begin
        dispense_A   = (r_state == S_VEND) && !r_prod_b;
        dispense_B   = (r_state == S_VEND) &&  r_prod_b;
        change_valid = (r_state == S_PAYOUT);
        change_coin  = 2'b00;
        if (r_state == S_PAYOUT) begin
            change_coin = (r_credit >= 6'd10) ? 2'b10 : 2'b01;
        end
        busy         = (r_state == S_VEND) || (r_state == S_PAYOUT);
        coin_reject  = r_coin_reject;
        credit       = r_credit;
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller.
module tb_vend_controller;

    logic       clk;
    logic       reset_n;
    logic [1:0] coin;
    logic [1:0] select;
    logic       hopper_ready;
    logic       dispense_A;
    logic       dispense_B;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    vend_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coin         (coin),
        .select       (select),
        .hopper_ready (hopper_ready),
        .dispense_A   (dispense_A),
        .dispense_B   (dispense_B),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one rising edge, then settle 1 time unit past it.
    task automatic step(input logic [1:0] c, input logic [1:0] s, input logic r);
        coin = c;
        select = s;
        hopper_ready = r;
        @(posedge clk);
        #1;
        coin = 2'b00;
        select = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0;
        coin = 2'b00;
        select = 2'b00;
        hopper_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_cv", change_valid, 0);
        check("rst_disp", {dispense_A, dispense_B}, 0);
        check("rst_rej", coin_reject, 0);
        reset_n = 1'b1;

        // Invalid coin in IDLE
        step(2'b11, 2'b00, 1'b0);
        check("inv_rej", coin_reject, 1);
        check("inv_credit", credit, 0);
        step(2'b00, 2'b00, 1'b0);
        check("inv_rej_pulse", coin_reject, 0);

        // Coin 10, buy A: exact price, no change
        step(2'b10, 2'b00, 1'b0);
        check("a_credit10", credit, 10);
        step(2'b00, 2'b01, 1'b0);
        check("a_dispA", dispense_A, 1);
        check("a_dispB", dispense_B, 0);
        check("a_busy", busy, 1);
        step(2'b00, 2'b00, 1'b0);
        check("a_dispA_end", dispense_A, 0);
        check("a_credit0", credit, 0);
        check("a_cv", change_valid, 0);
        check("a_idle", busy, 0);

        // Coins 10,10, buy B, hopper stalls 3 edges then accepts one 5-coin
        step(2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        check("b_credit20", credit, 20);
        step(2'b00, 2'b10, 1'b0);
        check("b_dispB", dispense_B, 1);
        check("b_dispA", dispense_A, 0);
        step(2'b00, 2'b00, 1'b0);
        check("b_dispB_end", dispense_B, 0);
        check("b_credit5", credit, 5);
        for (int i = 0; i < 3; i++) begin
            check("b_cv_hold", change_valid, 1);
            check("b_coin_hold", change_coin, 2'b01);
            check("b_credit_hold", credit, 5);
            step(2'b00, 2'b00, 1'b0);
        end
        check("b_cv_before_ready", change_valid, 1);
        step(2'b00, 2'b00, 1'b1);
        check("b_cv_done", change_valid, 0);
        check("b_coin_done", change_coin, 0);
        check("b_credit0", credit, 0);
        check("b_idle", busy, 0);
        hopper_ready = 1'b0;

        // Fill to 30, overflow coin rejected, cancel refunds three 10-coins
        step(2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        check("c_credit30", credit, 30);
        step(2'b01, 2'b00, 1'b0);
        check("c_over_rej", coin_reject, 1);
        check("c_credit_kept", credit, 30);
        step(2'b00, 2'b11, 1'b1);
        check("c_cancel_cv", change_valid, 1);
        check("c_cancel_coin", change_coin, 2'b10);
        check("c_cancel_credit", credit, 30);
        step(2'b00, 2'b00, 1'b1);
        check("c_pay1_credit", credit, 20);
        check("c_pay1_coin", change_coin, 2'b10);
        step(2'b00, 2'b00, 1'b1);
        check("c_pay2_credit", credit, 10);
        check("c_pay2_coin", change_coin, 2'b10);
        step(2'b00, 2'b00, 1'b1);
        check("c_pay3_credit", credit, 0);
        check("c_pay3_cv", change_valid, 0);
        check("c_idle", busy, 0);
        hopper_ready = 1'b0;

        // Cancel in IDLE is ignored
        step(2'b00, 2'b11, 1'b1);
        check("idle_cancel_cv", change_valid, 0);
        check("idle_cancel_busy", busy, 0);
        hopper_ready = 1'b0;

        // Insufficient credit; coin together with select
        step(2'b01, 2'b00, 1'b0);
        check("d_credit5", credit, 5);
        step(2'b00, 2'b01, 1'b0);
        check("d_noA", dispense_A, 0);
        check("d_nobusy", busy, 0);
        check("d_credit_keep", credit, 5);
        step(2'b10, 2'b10, 1'b0);
        check("d_noB", dispense_B, 0);
        check("d_same_rej", coin_reject, 1);
        check("d_credit_same", credit, 5);
        step(2'b00, 2'b11, 1'b1);
        check("d_refund_coin", change_coin, 2'b01);
        step(2'b00, 2'b00, 1'b1);
        check("d_refund_done", credit, 0);
        check("d_refund_cv", change_valid, 0);
        hopper_ready = 1'b0;

        // Coins 10,10, buy A, coin while busy, reset mid-PAYOUT
        step(2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        check("e_dispA", dispense_A, 1);
        step(2'b01, 2'b00, 1'b0);
        check("e_busy_rej", coin_reject, 1);
        check("e_pay_cv", change_valid, 1);
        check("e_pay_coin", change_coin, 2'b10);
        check("e_pay_credit", credit, 10);
        step(2'b00, 2'b10, 1'b0);
        check("e_sel_ignored", {dispense_A, dispense_B}, 0);
        check("e_still_pay", change_valid, 1);
        reset_n = 1'b0;
        #2;
        check("e_rst_cv", change_valid, 0);
        check("e_rst_coin", change_coin, 0);
        check("e_rst_credit", credit, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_rej", coin_reject, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(2'b01, 2'b00, 1'b0);
        check("e_resume_credit", credit, 5);
        check("e_resume_cv", change_valid, 0);

`ifdef VEND_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (!change_valid && waited < 400) begin
                step(2'b00, 2'b00, 1'b0);
                waited++;
            end
            check("t_timeout_seen", change_valid, 1);
            check("t_timeout_coin", change_coin, 2'b01);
            step(2'b00, 2'b00, 1'b1);
            check("t_timeout_credit", credit, 0);
            check("t_timeout_idle", busy, 0);
            hopper_ready = 1'b0;
        end
`else
        // Without the timeout, credit is held indefinitely
        repeat (300) step(2'b00, 2'b00, 1'b0);
        check("t_hold_credit", credit, 5);
        check("t_hold_cv", change_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
